// File: rtl/sensor_debouncer.sv
// Debounces the raw active-low fork and crank hall switch lines for the sensor manager.
// Optional stuck-low detection is compiled in when SENSOR_STUCK_DETECT_EN is defined.
module sensor_debouncer #(
   parameter int DEBOUNCE_CYCLES = 64,
   parameter int STUCK_CYCLES    = 64000
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic nFork_raw,
   input  logic nCrank_raw,
   output logic nFork_clean,
   output logic nCrank_clean,
   output logic fork_stuck,
   output logic crank_stuck
);

`ifdef SENSOR_STUCK_DETECT_EN
   localparam int CNT_MAX = STUCK_CYCLES;
   typedef enum logic [2:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK, STUCK} state_t;
`else
   localparam int CNT_MAX = DEBOUNCE_CYCLES;
   typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;
`endif

   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef SENSOR_STUCK_DETECT_EN
   localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYCLES - 1);
`endif

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 || STUCK_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
      $error("sensor_debouncer: illegal DEBOUNCE_CYCLES/STUCK_CYCLES");
   end

   // Bit 0 is the fork channel, bit 1 the crank channel.
   logic [1:0]    sync1_q, sync1_d;
   logic [1:0]    sync2_q, sync2_d;
   logic [1:0]    clean_q, clean_d;
   logic [1:0]    stuck_d;
   state_t        state_q [2];
   state_t        state_d [2];
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_SAT) ? v : v + CW'(1);
   endfunction

   always_comb begin
      sync1_d = {nCrank_raw, nFork_raw};
      sync2_d = sync1_q;
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            RELEASED: begin
               if (!sync2_q[i]) begin
                  state_d[i] = PRESS_CHK;
                  cnt_d[i]   = CW'(1);
               end else begin
                  cnt_d[i] = '0;
               end
            end
            PRESS_CHK: begin
               if (sync2_q[i]) begin
                  state_d[i] = RELEASED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i] = PRESSED;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = sat_inc(cnt_q[i]);
               end
            end
            PRESSED: begin
               if (sync2_q[i]) begin
                  state_d[i] = RELEASE_CHK;
                  cnt_d[i]   = CW'(1);
`ifdef SENSOR_STUCK_DETECT_EN
               end else if (cnt_q[i] == STUCK_LAST) begin
                  state_d[i] = STUCK;
                  cnt_d[i]   = '0;
`endif
               end else begin
                  cnt_d[i] = sat_inc(cnt_q[i]);
               end
            end
            RELEASE_CHK: begin
               if (!sync2_q[i]) begin
                  state_d[i] = PRESSED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i] = RELEASED;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = sat_inc(cnt_q[i]);
               end
            end
`ifdef SENSOR_STUCK_DETECT_EN
            // Parked magnet: wait for a clean release before counting again.
            STUCK: begin
               if (!sync2_q[i]) begin
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i] = RELEASED;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = sat_inc(cnt_q[i]);
               end
            end
`endif
            default: begin
               state_d[i] = RELEASED;
               cnt_d[i]   = '0;
            end
         endcase
         clean_d[i] = !((state_q[i] == PRESSED) || (state_q[i] == RELEASE_CHK));
`ifdef SENSOR_STUCK_DETECT_EN
         stuck_d[i] = (state_q[i] == STUCK);
`else
         stuck_d[i] = 1'b0;
`endif
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sync1_q <= '1;
         sync2_q <= '1;
         clean_q <= '1;
         state_q <= '{RELEASED, RELEASED};
         cnt_q   <= '{default: '0};
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         clean_q <= clean_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SENSOR_STUCK_DETECT_EN
   logic [1:0] stuck_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         stuck_q <= '0;
      end else begin
         stuck_q <= stuck_d;
      end
   end

   assign fork_stuck  = stuck_q[0];
   assign crank_stuck = stuck_q[1];
`else
   assign fork_stuck  = stuck_d[0];
   assign crank_stuck = stuck_d[1];
`endif

   assign nFork_clean  = clean_q[0];
   assign nCrank_clean = clean_q[1];

endmodule
